ppu_vram_dma_fetch: RTL and testbench

//  Fabric-side DMA master that copies a tile/sprite image from HPS SDRAM into PPU VRAM.

---
 rtl/ppu_vram_dma_fetch.sv | 129 ++++++++++++
 tb/tb_ppu_vram_dma_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_dma_fetch.sv
// DMA master that bursts 64-bit beats from HPS SDRAM and packs beat pairs into
// 128-bit PPU VRAM words, pulsing done when the whole image has been written.
module ppu_vram_dma_fetch #(
  parameter int SDRAM_AW  = 29,
  parameter int BURST_MAX = 8,
  parameter int VRAM_AW   = 12,
  parameter int LEN_W     = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SDRAM_AW-1:0] src_addr,
  input  logic [VRAM_AW-1:0]  dst_addr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic [SDRAM_AW-1:0] sdram_address,
  output logic [7:0]          sdram_burstcount,
  output logic                sdram_read,
  input  logic                sdram_waitrequest,
  input  logic [63:0]         sdram_readdata,
  input  logic                sdram_readdatavalid,
  output logic [VRAM_AW-1:0]  vram_wraddr,
  output logic                vram_wren,
  output logic [127:0]        vram_wrdata
);

  localparam int BEAT_W = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t              state;
  logic [SDRAM_AW-1:0] cur_src;
  logic [BEAT_W-1:0]   beats_left;
  logic [7:0]          burst_left;
  logic [VRAM_AW-1:0]  wr_ptr;
  logic                phase;
  logic [63:0]         low_beat;

  // Next burst size: a full BURST_MAX burst unless fewer beats remain.
  function automatic logic [7:0] burst_len(input logic [BEAT_W-1:0] beats);
    if (beats >= BEAT_W'(BURST_MAX)) return 8'(BURST_MAX);
    return 8'(beats);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      cur_src          <= '0;
      beats_left       <= '0;
      burst_left       <= '0;
      wr_ptr           <= '0;
      phase            <= 1'b0;
      low_beat         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      sdram_address    <= '0;
      sdram_burstcount <= '0;
      sdram_read       <= 1'b0;
      vram_wraddr      <= '0;
      vram_wren        <= 1'b0;
      vram_wrdata      <= '0;
    end else begin
      done      <= 1'b0;
      vram_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            cur_src    <= {src_addr[SDRAM_AW-1:1], 1'b0};
            wr_ptr     <= dst_addr;
            beats_left <= {len, 1'b0};
            phase      <= 1'b0;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state            <= REQ;
              sdram_read       <= 1'b1;
              sdram_address    <= {src_addr[SDRAM_AW-1:1], 1'b0};
              sdram_burstcount <= burst_len({len, 1'b0});
            end
          end
        end
        REQ: begin
          if (!sdram_waitrequest) begin
            sdram_read <= 1'b0;
            burst_left <= sdram_burstcount;
            cur_src    <= cur_src + SDRAM_AW'(sdram_burstcount);
            beats_left <= beats_left - BEAT_W'(sdram_burstcount);
            state      <= DATA;
          end
        end
        DATA: begin
          if (sdram_readdatavalid) begin
            burst_left <= burst_left - 8'd1;
            phase      <= ~phase;
            if (!phase) begin
              low_beat <= sdram_readdata;
            end else begin
              vram_wren   <= 1'b1;
              vram_wrdata <= {sdram_readdata, low_beat};
              vram_wraddr <= wr_ptr;
              wr_ptr      <= wr_ptr + VRAM_AW'(1);
            end
            // The next request is issued in the same cycle the final beat lands.
            if (burst_left == 8'd1) begin
              if (beats_left != '0) begin
                state            <= REQ;
                sdram_read       <= 1'b1;
                sdram_address    <= cur_src;
                sdram_burstcount <= burst_len(beats_left);
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_vram_dma_fetch.sv
// Directed bench for ppu_vram_dma_fetch: an SDRAM slave model with optional
// waitrequest stalls feeds address-derived beats; VRAM writes are logged and checked.
module tb_ppu_vram_dma_fetch;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [28:0]  src_addr;
  logic [11:0]  dst_addr;
  logic [12:0]  len;
  logic         busy;
  logic         done;
  logic [28:0]  sdram_address;
  logic [7:0]   sdram_burstcount;
  logic         sdram_read;
  logic         sdram_waitrequest;
  logic [63:0]  sdram_readdata;
  logic         sdram_readdatavalid;
  logic [11:0]  vram_wraddr;
  logic         vram_wren;
  logic [127:0] vram_wrdata;

  int passed = 0;
  int total  = 0;
  int stall_cfg = 0;

  logic [11:0]  wa_q[$];
  logic [127:0] wd_q[$];
  logic [28:0]  ba_q[$];
  logic [7:0]   bc_q[$];
  int done_cnt = 0;
  int read_cyc = 0;
  int stall_seen = 0;
  int unstable = 0;

  always #5 clk = ~clk;

  ppu_vram_dma_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done),
    .sdram_address(sdram_address), .sdram_burstcount(sdram_burstcount),
    .sdram_read(sdram_read), .sdram_waitrequest(sdram_waitrequest),
    .sdram_readdata(sdram_readdata), .sdram_readdatavalid(sdram_readdatavalid),
    .vram_wraddr(vram_wraddr), .vram_wren(vram_wren), .vram_wrdata(vram_wrdata)
  );

  // Every beat is a function of its SDRAM word address so misordering shows up.
  function automatic logic [63:0] beat(input logic [28:0] a);
    return {6'h2A, a, a ^ 29'h1555_5555};
  endfunction

  function automatic logic [127:0] exp_word(input logic [28:0] src, input int i);
    return {beat(src + 29'(2 * i + 1)), beat(src + 29'(2 * i))};
  endfunction

  // SDRAM slave: decides waitrequest at the negedge, then returns one beat per cycle.
  initial begin : slave
    int pending;
    int stall_left;
    bit in_req;
    logic [28:0] next_addr, hold_a;
    logic [7:0]  hold_c;
    pending = 0; stall_left = 0; in_req = 0;
    next_addr = '0; hold_a = '0; hold_c = '0;
    sdram_waitrequest = 1'b0;
    sdram_readdatavalid = 1'b0;
    sdram_readdata = '0;
    forever begin
      @(negedge clk);
      sdram_readdatavalid = 1'b0;
      if (!rst_n) begin
        pending = 0;
        in_req = 0;
        sdram_waitrequest = 1'b0;
      end else if (pending > 0) begin
        sdram_readdatavalid = 1'b1;
        sdram_readdata = beat(next_addr);
        next_addr = next_addr + 29'd1;
        pending--;
      end else if (sdram_read) begin
        if (!in_req) begin
          in_req = 1;
          stall_left = stall_cfg;
          hold_a = sdram_address;
          hold_c = sdram_burstcount;
        end else if (sdram_address !== hold_a || sdram_burstcount !== hold_c) begin
          unstable++;
        end
        if (stall_left > 0) begin
          sdram_waitrequest = 1'b1;
          stall_left--;
          stall_seen++;
        end else begin
          sdram_waitrequest = 1'b0;
          ba_q.push_back(sdram_address);
          bc_q.push_back(sdram_burstcount);
          pending = int'(sdram_burstcount);
          next_addr = sdram_address;
          in_req = 0;
        end
      end else begin
        sdram_waitrequest = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (vram_wren) begin
      wa_q.push_back(vram_wraddr);
      wd_q.push_back(vram_wrdata);
    end
    if (done) done_cnt++;
    if (sdram_read) read_cyc++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Runs one transfer to completion; poke re-asserts start mid-transfer.
  task automatic applyStimulus(input logic [28:0] src, input logic [11:0] dst,
                               input logic [12:0] ln, input int stall, input bit poke,
                               output int w0, output int b0, output int d0);
    bit timed_out;
    w0 = wa_q.size();
    b0 = ba_q.size();
    d0 = done_cnt;
    stall_cfg = stall;
    @(negedge clk);
    src_addr = src; dst_addr = dst; len = ln; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    timed_out = 1;
    for (int i = 0; i < 2000; i++) begin
      if (poke && i == 6) begin
        src_addr = 29'h7000; dst_addr = 12'h555; len = 13'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        timed_out = 0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("done_timeout", 128'(timed_out), 128'd0);
    checkOutput("done_count", 128'(done_cnt - d0), 128'd1);
    checkOutput("busy_after", 128'(busy), 128'd0);
  endtask

  initial begin
    int w0, b0, d0, r0, s0, u0;
    bit seen;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", {busy, done, sdram_read, vram_wren}, 4'b0);
    checkOutput("reset_addr", {sdram_address, sdram_burstcount, vram_wraddr}, '0);
    checkOutput("reset_data", vram_wrdata, '0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single word");
    applyStimulus(29'h100, 12'h010, 13'd1, 0, 0, w0, b0, d0);
    checkOutput("t1_bursts", 128'(ba_q.size() - b0), 128'd1);
    checkOutput("t1_baddr", ba_q[b0], 29'h100);
    checkOutput("t1_bcount", bc_q[b0], 8'd2);
    checkOutput("t1_writes", 128'(wa_q.size() - w0), 128'd1);
    checkOutput("t1_waddr", wa_q[w0], 12'h010);
    checkOutput("t1_wdata", wd_q[w0], {beat(29'h101), beat(29'h100)});

    $display("[TB] ten words, odd source, start while busy");
    applyStimulus(29'h201, 12'h020, 13'd10, 0, 1, w0, b0, d0);
    checkOutput("t2_bursts", 128'(ba_q.size() - b0), 128'd3);
    checkOutput("t2_baddr0", ba_q[b0], 29'h200);
    checkOutput("t2_baddr1", ba_q[b0 + 1], 29'h208);
    checkOutput("t2_baddr2", ba_q[b0 + 2], 29'h210);
    checkOutput("t2_bcount0", bc_q[b0], 8'd8);
    checkOutput("t2_bcount1", bc_q[b0 + 1], 8'd8);
    checkOutput("t2_bcount2", bc_q[b0 + 2], 8'd4);
    checkOutput("t2_writes", 128'(wa_q.size() - w0), 128'd10);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t2_waddr%0d", i), wa_q[w0 + i], 12'h020 + 12'(i));
      checkOutput($sformatf("t2_wdata%0d", i), wd_q[w0 + i], exp_word(29'h200, i));
    end

    $display("[TB] stalled request");
    s0 = stall_seen; u0 = unstable;
    applyStimulus(29'h300, 12'h040, 13'd2, 5, 0, w0, b0, d0);
    checkOutput("t3_stall_cycles", 128'(stall_seen - s0), 128'd5);
    checkOutput("t3_unstable", 128'(unstable - u0), 128'd0);
    checkOutput("t3_bursts", 128'(ba_q.size() - b0), 128'd1);
    checkOutput("t3_bcount", bc_q[b0], 8'd4);
    checkOutput("t3_wdata0", wd_q[w0], exp_word(29'h300, 0));
    checkOutput("t3_wdata1", wd_q[w0 + 1], exp_word(29'h300, 1));

    $display("[TB] VRAM address wrap");
    applyStimulus(29'h400, 12'hFFE, 13'd4, 0, 0, w0, b0, d0);
    checkOutput("t4_waddr0", wa_q[w0], 12'hFFE);
    checkOutput("t4_waddr1", wa_q[w0 + 1], 12'hFFF);
    checkOutput("t4_waddr2", wa_q[w0 + 2], 12'h000);
    checkOutput("t4_waddr3", wa_q[w0 + 3], 12'h001);
    checkOutput("t4_wdata3", wd_q[w0 + 3], exp_word(29'h400, 3));

    $display("[TB] zero length");
    w0 = wa_q.size(); d0 = done_cnt; r0 = read_cyc;
    @(negedge clk);
    src_addr = 29'h123; dst_addr = 12'h0AA; len = 13'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t5_done_next", {busy, done}, 2'b11);
    @(negedge clk);
    checkOutput("t5_done_gone", {busy, done}, 2'b00);
    repeat (2) @(negedge clk);
    checkOutput("t5_no_read", 128'(read_cyc - r0), 128'd0);
    checkOutput("t5_no_write", 128'(wa_q.size() - w0), 128'd0);
    checkOutput("t5_done_count", 128'(done_cnt - d0), 128'd1);

    $display("[TB] reset mid transfer");
    w0 = wa_q.size();
    @(negedge clk);
    src_addr = 29'h500; dst_addr = 12'h080; len = 13'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (vram_wren) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t6_reached_data", 128'(seen), 128'd1);
    rst_n = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    checkOutput("t6_reset_ctrl", {busy, done, sdram_read, vram_wren}, 4'b0);
    checkOutput("t6_reset_addr", {sdram_address, sdram_burstcount, vram_wraddr}, '0);
    checkOutput("t6_reset_data", vram_wrdata, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("t6_no_done", 128'(done_cnt - d0), 128'd0);
    applyStimulus(29'h600, 12'h0C0, 13'd3, 0, 0, w0, b0, d0);
    checkOutput("t6_bcount", bc_q[b0], 8'd6);
    checkOutput("t6_writes", 128'(wa_q.size() - w0), 128'd3);
    checkOutput("t6_waddr0", wa_q[w0], 12'h0C0);
    checkOutput("t6_wdata2", wd_q[w0 + 2], exp_word(29'h600, 2));
    checkOutput("t6_waddr2", wa_q[w0 + 2], 12'h0C2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
